// File: rtl/bcd_mem_unpacker_pkg.sv
// Shared definitions for the packed-BCD load sequencer.
//   - state_t    : sequencer FSM encoding
//   - BCD_MAX    : largest legal decimal nibble
//   - get_nibble : extracts nibble idx from a 32-bit word
package bcd_mem_unpacker_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int REG_IDX_W  = 5;
    localparam int WORD_W     = 32;
    localparam int MAX_DIGITS = WORD_W / NIBBLE_W;
    localparam int CNT_W      = 3;   // digit index 0..7

    localparam logic [NIBBLE_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CHECK,
        WRITE,
        SUMWR,
        DONE,
        ERR
    } state_t;

    function automatic logic [NIBBLE_W-1:0] get_nibble(
        input logic [WORD_W-1:0] word,
        input logic [CNT_W-1:0]  idx
    );
        return word[idx*NIBBLE_W +: NIBBLE_W];
    endfunction

endpackage

// File: rtl/bcd_mem_unpacker_check.sv
// bcd_word_check: combinational BCD legality check of one 32-bit word.
//   i_word         : packed word, nibble 0 in bits [3:0]
//   o_nibble_valid : per-nibble flag, 1 when the nibble is 0..9 (all 8 nibbles)
//   o_all_valid    : 1 when nibbles [DIGITS-1:0] are all legal; upper nibbles ignored
module bcd_word_check
    import bcd_mem_unpacker_pkg::*;
#(
    parameter int DIGITS = 6
) (
    input  logic [WORD_W-1:0]     i_word,
    output logic [MAX_DIGITS-1:0] o_nibble_valid,
    output logic                  o_all_valid
);

    // NOTE: every bit of o_nibble_valid is written on every pass through this
    // block, so no storage (latch) can be inferred.
    always_comb begin
        o_nibble_valid = '0;
        for (int n = 0; n < MAX_DIGITS; n++) begin
            o_nibble_valid[n] = (i_word[n*NIBBLE_W +: NIBBLE_W] <= BCD_MAX);
        end
    end

    assign o_all_valid = &o_nibble_valid[DIGITS-1:0];

endmodule

// File: rtl/bcd_mem_unpacker.sv
// bcd_mem_unpacker: fetches one packed-BCD word from dataMem, writes its DIGITS
// decimal digits (MSD first, into BASE_REG upwards) to regsFile one per cycle,
// then writes the digit sum to SUM_REG.
//   clk, rst_n         : clock, asynchronous active-low reset
//   start, baseAddr    : request and word address, sampled in IDLE only
//   address, memRead   : dataMem read port (active in READ only)
//   readData           : dataMem combinational read data
//   regWrite, rgw1,    : regsFile write port, one pulse per register,
//   rgw1data           : index/data forced to 0 when not writing
//   busy, done, error  : status; error qualifies the one-cycle done pulse
//   sum                : digit sum of the last run, held until the next start
module bcd_mem_unpacker
    import bcd_mem_unpacker_pkg::*;
#(
    parameter int DIGITS   = 6,
    parameter int BASE_REG = 20,
    parameter int SUM_REG  = 31,
    parameter int ADDR_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    baseAddr,
    output logic [ADDR_W-1:0]    address,
    output logic                 memRead,
    input  logic [WORD_W-1:0]    readData,
    output logic                 regWrite,
    output logic [REG_IDX_W-1:0] rgw1,
    output logic [WORD_W-1:0]    rgw1data,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [WORD_W-1:0]    sum
);

    state_t                 r_state;
    logic [WORD_W-1:0]      r_word;
    logic [WORD_W-1:0]      r_sum;
    logic [CNT_W-1:0]       r_idx;
    logic [ADDR_W-1:0]      r_address;
    logic                   r_mem_read;
    logic                   r_reg_write;
    logic [REG_IDX_W-1:0]   r_rgw1;
    logic [WORD_W-1:0]      r_rgw1data;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_error;

    logic                   w_all_valid;
    logic [MAX_DIGITS-1:0]  w_nibble_valid_unused;  // per-digit flags not needed by the sequencer
    logic [NIBBLE_W-1:0]    w_cur_nibble;
    logic [NIBBLE_W-1:0]    w_next_nibble;
    logic [WORD_W-1:0]      w_sum_next;

    bcd_word_check #(
        .DIGITS (DIGITS)
    ) u_check (
        .i_word         (r_word),
        .o_nibble_valid (w_nibble_valid_unused),
        .o_all_valid    (w_all_valid)
    );

    assign w_cur_nibble  = get_nibble(r_word, r_idx);
    assign w_next_nibble = get_nibble(r_word, r_idx - 1'b1);
    assign w_sum_next    = r_sum + {{(WORD_W-NIBBLE_W){1'b0}}, w_cur_nibble};

    // Outputs are registered alongside the state: each one is loaded at the
    // edge that enters the state in which it must be visible.
    // NOTE: reset asserts asynchronously; deassertion is expected to arrive
    // already synchronised to clk from the reset controller.
    // NOTE: state and outputs use non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_word      <= '0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_address   <= '0;
            r_mem_read  <= 1'b0;
            r_reg_write <= 1'b0;
            r_rgw1      <= '0;
            r_rgw1data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= READ;
                        r_address  <= baseAddr;
                        r_mem_read <= 1'b1;
                        r_busy     <= 1'b1;
                        r_sum      <= '0;
                    end
                end
                READ: begin
                    r_word     <= readData;
                    r_address  <= '0;
                    r_mem_read <= 1'b0;
                    r_state    <= CHECK;
                end
                CHECK: begin
                    if (!w_all_valid) begin
                        r_state <= ERR;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_error <= 1'b1;
                        r_sum   <= '0;
                    end else begin
                        // Present the MSD during the first WRITE cycle.
                        r_state     <= WRITE;
                        r_idx       <= CNT_W'(DIGITS - 1);
                        r_reg_write <= 1'b1;
                        r_rgw1      <= REG_IDX_W'(BASE_REG);
                        r_rgw1data  <= {{(WORD_W-NIBBLE_W){1'b0}},
                                        get_nibble(r_word, CNT_W'(DIGITS - 1))};
                    end
                end
                WRITE: begin
                    r_sum <= w_sum_next;
                    if (r_idx == '0) begin
                        // Last digit: the sum including it goes out next cycle.
                        r_state    <= SUMWR;
                        r_rgw1     <= REG_IDX_W'(SUM_REG);
                        r_rgw1data <= w_sum_next;
                    end else begin
                        r_idx      <= r_idx - 1'b1;
                        r_rgw1     <= r_rgw1 + 1'b1;
                        r_rgw1data <= {{(WORD_W-NIBBLE_W){1'b0}}, w_next_nibble};
                    end
                end
                SUMWR: begin
                    r_state     <= DONE;
                    r_reg_write <= 1'b0;
                    r_rgw1      <= '0;
                    r_rgw1data  <= '0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                end
                DONE, ERR: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_error <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign address  = r_address;
    assign memRead  = r_mem_read;
    assign regWrite = r_reg_write;
    assign rgw1     = r_rgw1;
    assign rgw1data = r_rgw1data;
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;
    assign sum      = r_sum;

endmodule

// File: tb/tb_bcd_mem_unpacker.sv
// Self-checking bench for bcd_mem_unpacker (DIGITS=6, BASE_REG=20, SUM_REG=31).
// The bench models dataMem (8 words) and regsFile (32 entries).
module tb_bcd_mem_unpacker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] baseAddr = '0;
    logic [31:0] address;
    logic        memRead;
    logic [31:0] readData;
    logic        regWrite;
    logic [4:0]  rgw1;
    logic [31:0] rgw1data;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] sum;

    logic [31:0] mem [8];
    logic [31:0] regs [32];

    int n_checks = 0;
    int n_fail   = 0;
    int wr_pulses = 0;
    int done_pulses = 0;
    int rd_cycles = 0;

    always #5 clk = ~clk;

    bcd_mem_unpacker #(
        .DIGITS   (6),
        .BASE_REG (20),
        .SUM_REG  (31),
        .ADDR_W   (32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .baseAddr (baseAddr),
        .address  (address),
        .memRead  (memRead),
        .readData (readData),
        .regWrite (regWrite),
        .rgw1     (rgw1),
        .rgw1data (rgw1data),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .sum      (sum)
    );

    assign readData = memRead ? mem[address[4:2]] : 32'h0;

    always @(posedge clk) begin
        if (regWrite) begin
            regs[rgw1] <= rgw1data;
            wr_pulses  <= wr_pulses + 1;
        end
        if (done)    done_pulses <= done_pulses + 1;
        if (memRead) rd_cycles   <= rd_cycles + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Bus hygiene checked every cycle outside reset.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!regWrite) begin
                check("idle_rgw1", {27'b0, rgw1}, 32'h0);
                check("idle_rgw1data", rgw1data, 32'h0);
            end
            if (!memRead) check("idle_address", address, 32'h0);
            if (!done)    check("error_without_done", {31'b0, error}, 32'h0);
        end
    end

    // One start pulse; returns cycles from the accepting edge k to done (-1 on timeout).
    task automatic run(input logic [31:0] a, output int lat, output logic err);
        lat = -1;
        err = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        baseAddr = a;
        @(negedge clk);
        start    = 1'b0;
        baseAddr = '0;
        check("read_memRead", {31'b0, memRead}, 32'h1);
        check("read_address", address, a);
        check("read_busy", {31'b0, busy}, 32'h1);
        for (int n = 1; n <= 40; n++) begin
            if (done) begin
                lat = n;
                err = error;
                check("done_busy", {31'b0, busy}, 32'h0);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        check("done_pulse_width", {31'b0, done}, 32'h0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        logic        exp_err;
        logic [31:0] exp_sum;
        logic [23:0] exp_digits;  // reg20 digit in [23:20] ... reg25 digit in [3:0]
    } vec_t;

    vec_t vecs [6];

    initial begin
        int          lat;
        logic        err;
        logic [31:0] snap [32];
        logic [23:0] dg;
        logic [31:0] va;
        int          w0, d0, r0;
        int          rd_at [2];
        int          dn_at [2];
        int          nr, nd;

        for (int i = 0; i < 8; i++) mem[i] = 32'h0;

        vecs[0] = '{32'h0, 32'h0052_2479, 1'b0, 32'd29, 24'h522479};
        vecs[1] = '{32'h0, 32'h005A_2479, 1'b1, 32'd0,  24'h000000};
        vecs[2] = '{32'h4, 32'h0099_9999, 1'b0, 32'd54, 24'h999999};
        vecs[3] = '{32'h0, 32'hFF52_2479, 1'b0, 32'd29, 24'h522479};
        vecs[4] = '{32'h0, 32'h0000_0000, 1'b0, 32'd0,  24'h000000};
        vecs[5] = '{32'h0, 32'h0052_247A, 1'b1, 32'd0,  24'h000000};

        // Reset state
        #12;
        check("rst_address",  address, 32'h0);
        check("rst_memRead",  {31'b0, memRead}, 32'h0);
        check("rst_regWrite", {31'b0, regWrite}, 32'h0);
        check("rst_rgw1",     {27'b0, rgw1}, 32'h0);
        check("rst_rgw1data", rgw1data, 32'h0);
        check("rst_busy",     {31'b0, busy}, 32'h0);
        check("rst_done",     {31'b0, done}, 32'h0);
        check("rst_error",    {31'b0, error}, 32'h0);
        check("rst_sum",      sum, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven runs
        for (int i = 0; i < 6; i++) begin
            va = vecs[i].addr;
            mem[va[4:2]] = vecs[i].word;
            for (int r = 0; r < 32; r++) snap[r] = regs[r];
            w0 = wr_pulses;
            run(vecs[i].addr, lat, err);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_err ? 32'd3 : 32'd10);
            check($sformatf("v%0d_error", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
            check($sformatf("v%0d_sum", i), sum, vecs[i].exp_sum);
            check($sformatf("v%0d_pulses", i), wr_pulses - w0, vecs[i].exp_err ? 32'd0 : 32'd7);
            dg = vecs[i].exp_digits;
            for (int j = 0; j < 6; j++)
                check($sformatf("v%0d_reg%0d", i, 20 + j), regs[20 + j],
                      vecs[i].exp_err ? snap[20 + j] : {28'b0, dg[(5 - j)*4 +: 4]});
            check($sformatf("v%0d_reg31", i), regs[31],
                  vecs[i].exp_err ? snap[31] : vecs[i].exp_sum);
        end

        // Start pulses while busy are ignored
        mem[0] = 32'h0052_2479;
        mem[1] = 32'h0099_9999;
        d0 = done_pulses; r0 = rd_cycles; w0 = wr_pulses;
        @(negedge clk);
        start = 1'b1; baseAddr = 32'h0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            start    = (n >= 2 && n <= 8);
            baseAddr = 32'h4;
        end
        start = 1'b0; baseAddr = '0;
        check("busy_start_dones", done_pulses - d0, 32'd1);
        check("busy_start_reads", rd_cycles - r0, 32'd1);
        check("busy_start_pulses", wr_pulses - w0, 32'd7);
        check("busy_start_sum", sum, 32'd29);

        // start held high across DONE: next run accepted at the first IDLE edge
        rd_at = '{-1, -1};
        dn_at = '{-1, -1};
        nr = 0; nd = 0;
        @(negedge clk);
        start = 1'b1; baseAddr = 32'h0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (memRead && nr < 2) begin rd_at[nr] = n; nr++; end
            if (done && nd < 2)    begin dn_at[nd] = n; nd++; end
            if (n == 12) start = 1'b0;
        end
        check("held_read1", rd_at[0], 32'd1);
        check("held_read2", rd_at[1], 32'd12);
        check("held_done1", dn_at[0], 32'd10);
        check("held_done2", dn_at[1], 32'd21);

        // Reset during WRITE after three digits
        run(32'h4, lat, err);
        check("pre_rst_sum", sum, 32'd54);
        mem[0] = 32'h0052_2479;
        d0 = done_pulses;
        @(negedge clk);
        start = 1'b1; baseAddr = 32'h0;
        @(negedge clk);
        start = 1'b0; baseAddr = '0;
        repeat (5) @(negedge clk);
        check("pre_rst_rgw1", {27'b0, rgw1}, 32'd23);
        rst_n = 1'b0;
        #1;
        check("mid_rst_address",  address, 32'h0);
        check("mid_rst_memRead",  {31'b0, memRead}, 32'h0);
        check("mid_rst_regWrite", {31'b0, regWrite}, 32'h0);
        check("mid_rst_rgw1",     {27'b0, rgw1}, 32'h0);
        check("mid_rst_rgw1data", rgw1data, 32'h0);
        check("mid_rst_busy",     {31'b0, busy}, 32'h0);
        check("mid_rst_done",     {31'b0, done}, 32'h0);
        check("mid_rst_error",    {31'b0, error}, 32'h0);
        check("mid_rst_sum",      sum, 32'h0);
        repeat (3) @(negedge clk);
        check("mid_rst_no_done", done_pulses - d0, 32'd0);
        check("mid_rst_reg20", regs[20], 32'd5);
        check("mid_rst_reg21", regs[21], 32'd2);
        check("mid_rst_reg22", regs[22], 32'd2);
        check("mid_rst_reg23", regs[23], 32'd9);
        check("mid_rst_reg24", regs[24], 32'd9);
        check("mid_rst_reg25", regs[25], 32'd9);
        rst_n = 1'b1;
        run(32'h0, lat, err);
        check("post_rst_latency", lat, 32'd10);
        check("post_rst_error", {31'b0, err}, 32'h0);
        check("post_rst_sum", sum, 32'd29);
        check("post_rst_reg23", regs[23], 32'd4);
        check("post_rst_reg24", regs[24], 32'd7);
        check("post_rst_reg25", regs[25], 32'd9);
        check("post_rst_reg31", regs[31], 32'd29);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
